kmkz_dm_responder: RTL and testbench

//  Data-memory responder (target side) of the core's dm_* interface: accepts load/store requests,

---
 rtl/kmkz_dm_responder.sv | 198 +++++++++++++++++++
 tb/tb_kmkz_dm_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmkz_dm_responder.sv
// ---------------------------------------------------------------------------
// kmkz_dm_responder
//   Target side of the core's dm_* data-memory interface. Accepts one
//   load or store at a time, serves it from on-chip word RAM after
//   g_wait_states extra cycles, and returns a one-cycle done strobe
//   (plus load data) to the CPU writeback stage.
//
//   Optional build macro: KMKZ_DM_ERR_EN
//     defined   - out-of-window accesses are flagged on dm_err_o, stores to
//                 them are dropped and loads return zero.
//     undefined - no dm_err_o port; out-of-window addresses alias into RAM.
//
// Ports
//   clk_i             rising-edge clock
//   rst_i             asynchronous reset, active-low
//   dm_addr_i         byte address, bits [1:0] ignored
//   dm_data_s_i       store data, lane-aligned
//   dm_data_select_i  byte enables, bit i -> lane [8i+7:8i]
//   dm_store_i        store request (wins over a simultaneous load)
//   dm_load_i         load request
//   dm_ready_o        high while idle; a request is taken on this cycle's edge
//   dm_data_l_o       full load word, held until the next load_done
//   dm_load_done_o    one-cycle pulse, dm_data_l_o valid
//   dm_store_done_o   one-cycle pulse, store committed
//   dm_err_o          one-cycle pulse alongside done (KMKZ_DM_ERR_EN only)
// ---------------------------------------------------------------------------
module kmkz_dm_responder #(
    parameter int unsigned g_mem_words   = 1024,
    parameter int unsigned g_wait_states = 1,
    parameter logic [31:0] g_base_addr   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
`ifdef KMKZ_DM_ERR_EN
    output logic        dm_store_done_o,
    output logic        dm_err_o
`else
    output logic        dm_store_done_o
`endif
);

    localparam int unsigned AW = $clog2(g_mem_words);
    localparam logic [3:0] WAIT_INIT =
        (g_wait_states > 0) ? 4'(g_wait_states - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [3:0]      cnt;

    logic            accept;
    logic            enter_resp;
    logic [AW-1:0]   idx_in;
    logic [AW-1:0]   cur_idx;
    logic            cur_store;

    // Transaction registers captured at accept (datapath, not reset)
    logic [AW-1:0]   idx_q;
    logic [31:0]     data_q;
    logic [3:0]      sel_q;
    logic            store_q;

    logic [31:0]     mem [g_mem_words];

`ifdef KMKZ_DM_ERR_EN
    logic [31:0]     offset;
    logic            in_win;
    logic            err_q;
    logic            cur_err;

    // An address below the base wraps to a huge offset, so a single
    // unsigned compare covers both window edges.
    assign offset  = dm_addr_i - g_base_addr;
    assign in_win  = offset < 32'(4 * g_mem_words);
    assign idx_in  = AW'(offset >> 2);
    assign cur_err = (state == S_IDLE) ? ~in_win : err_q;
`else
    assign idx_in  = AW'((dm_addr_i - g_base_addr) >> 2);
`endif

    assign accept     = (state == S_IDLE) && (dm_load_i || dm_store_i);
    assign dm_ready_o = (state == S_IDLE);

    // With zero wait states the RAM is read on the accept edge itself, so
    // the request fields come straight from the inputs; otherwise from the
    // captured copy.
    assign cur_idx   = (state == S_IDLE) ? idx_in     : idx_q;
    assign cur_store = (state == S_IDLE) ? dm_store_i : store_q;

    // -- FSM state register ---------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -- FSM next-state ---------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = (g_wait_states == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign enter_resp = (next_state == S_RESP);

    // -- Accept stage: capture request --------------------------------------
    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_q   <= idx_in;
            data_q  <= dm_data_s_i;
            sel_q   <= dm_data_select_i;
            store_q <= dm_store_i;
`ifdef KMKZ_DM_ERR_EN
            err_q   <= ~in_win;
`endif
        end
    end

    // -- Wait counter and registered response outputs -----------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt             <= 4'd0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_data_l_o     <= 32'h0000_0000;
`ifdef KMKZ_DM_ERR_EN
            dm_err_o        <= 1'b0;
`endif
        end else begin
            if (accept) begin
                cnt <= WAIT_INIT;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            dm_load_done_o  <= enter_resp && !cur_store;
            dm_store_done_o <= enter_resp &&  cur_store;
`ifdef KMKZ_DM_ERR_EN
            dm_err_o        <= enter_resp && cur_err;
`endif

            // Synchronous RAM read lands directly in the output register,
            // which then holds until the next load completes.
            if (enter_resp && !cur_store) begin
`ifdef KMKZ_DM_ERR_EN
                dm_data_l_o <= cur_err ? 32'h0000_0000 : mem[cur_idx];
`else
                dm_data_l_o <= mem[cur_idx];
`endif
            end
        end
    end

    // -- Response stage: byte-lane store commit -------------------------------
    // Written on the edge that leaves RESP; a reset before then forces the
    // FSM out of RESP, so an aborted store never reaches the array.
    always_ff @(posedge clk_i) begin
`ifdef KMKZ_DM_ERR_EN
        if ((state == S_RESP) && store_q && !err_q) begin
`else
        if ((state == S_RESP) && store_q) begin
`endif
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_kmkz_dm_responder.sv
module tb_kmkz_dm_responder;

    localparam int unsigned WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct packed {
        logic        is_store;
        logic        err;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT with one wait state
    logic [31:0] addr1, sdata1, ldata1;
    logic [3:0]  sel1;
    logic        st1, ld1, ready1, ld_done1, st_done1;
    // DUT with zero wait states
    logic [31:0] addr0, sdata0, ldata0;
    logic [3:0]  sel0;
    logic        st0, ld0, ready0, ld_done0, st_done0;
`ifdef KMKZ_DM_ERR_EN
    logic        err1, err0;
`endif

    kmkz_dm_responder #(
        .g_mem_words  (WORDS),
        .g_wait_states(1),
        .g_base_addr  (BASE)
    ) u_dut1 (
        .clk_i           (clk),
        .rst_i           (rst),
        .dm_addr_i       (addr1),
        .dm_data_s_i     (sdata1),
        .dm_data_select_i(sel1),
        .dm_store_i      (st1),
        .dm_load_i       (ld1),
        .dm_ready_o      (ready1),
        .dm_data_l_o     (ldata1),
        .dm_load_done_o  (ld_done1),
`ifdef KMKZ_DM_ERR_EN
        .dm_store_done_o (st_done1),
        .dm_err_o        (err1)
`else
        .dm_store_done_o (st_done1)
`endif
    );

    kmkz_dm_responder #(
        .g_mem_words  (WORDS),
        .g_wait_states(0),
        .g_base_addr  (BASE)
    ) u_dut0 (
        .clk_i           (clk),
        .rst_i           (rst),
        .dm_addr_i       (addr0),
        .dm_data_s_i     (sdata0),
        .dm_data_select_i(sel0),
        .dm_store_i      (st0),
        .dm_load_i       (ld0),
        .dm_ready_o      (ready0),
        .dm_data_l_o     (ldata0),
        .dm_load_done_o  (ld_done0),
`ifdef KMKZ_DM_ERR_EN
        .dm_store_done_o (st_done0),
        .dm_err_o        (err0)
`else
        .dm_store_done_o (st_done0)
`endif
    );

    int   vectors     = 0;
    int   miscompares = 0;
    sb_t  q1[$];
    sb_t  q0[$];
    logic [31:0] model [2][WORDS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one access; updates the bench's memory image.
    task automatic mk_exp(input int u, input logic st, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] sel, output sb_t e);
        int unsigned w;
        w = ((a - BASE) >> 2) % WORDS;
        e.is_store = st;
        e.err      = 1'b0;
`ifdef KMKZ_DM_ERR_EN
        e.err      = !(((a - BASE) >> 2) < WORDS);
`endif
        e.data     = 32'h0;
        if (st) begin
            if (!e.err) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) model[u][w][8*i +: 8] = d[8*i +: 8];
                end
            end
        end else begin
            e.data = e.err ? 32'h0 : model[u][w];
        end
    endtask

    // One complete transaction on the one-wait-state DUT.
    task automatic txn1(input logic st, input logic ld, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel);
        sb_t e;
        sb_t g;
        int  lat;
        bit  got;
        mk_exp(1, st, a, d, sel, e);
        q1.push_back(e);
        @(negedge clk);
        chk("ready_idle", 32'(ready1), 32'd1);
        st1 = st; ld1 = ld; addr1 = a; sdata1 = d; sel1 = sel;
        @(negedge clk);
        st1 = 1'b0; ld1 = 1'b0;
        chk("ready_busy", 32'(ready1), 32'd0);
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            if (ld_done1 || st_done1) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        g = q1.pop_front();
        if (got) begin
            chk("latency", 32'(lat), 32'd2);
            chk("ready_resp", 32'(ready1), 32'd0);
            chk("store_done", 32'(st_done1), 32'(g.is_store));
            chk("load_done", 32'(ld_done1), 32'(!g.is_store));
            if (!g.is_store) chk("load_data", ldata1, g.data);
`ifdef KMKZ_DM_ERR_EN
            chk("err", 32'(err1), 32'(g.err));
`endif
            @(negedge clk);
            chk("done_clear", 32'({ld_done1, st_done1}), 32'd0);
            chk("ready_back", 32'(ready1), 32'd1);
        end
    endtask

    // Four accesses on the zero-wait DUT with the request held high throughout.
    task automatic burst0(input logic st);
        sb_t e;
        sb_t g;
        int  issued = 0;
        int  dones  = 0;
        int  cyc    = 0;
        int  last   = -1;
        logic [31:0] a, d;
        while (dones < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ld_done0 || st_done0) begin
                chk("n0_queue", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) begin
                    g = q0.pop_front();
                    chk("n0_store_done", 32'(st_done0), 32'(g.is_store));
                    chk("n0_load_done", 32'(ld_done0), 32'(!g.is_store));
                    if (!g.is_store) chk("n0_load_data", ldata0, g.data);
                end
                if (last >= 0) chk("n0_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                dones++;
            end
            if (ready0) begin
                if (issued < 4) begin
                    a = 32'h40 + 32'(4 * issued);
                    d = st ? (32'hC0DE_0000 | 32'(issued)) : 32'h0;
                    mk_exp(0, st, a, d, 4'hF, e);
                    q0.push_back(e);
                    st0 = st; ld0 = !st; addr0 = a; sdata0 = d; sel0 = 4'hF;
                    issued++;
                end else begin
                    st0 = 1'b0; ld0 = 1'b0;
                end
            end
        end
        st0 = 1'b0; ld0 = 1'b0;
        chk("n0_count", 32'(dones), 32'd4);
        @(negedge clk);
        chk("n0_quiet", 32'({ld_done0, st_done0}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        st1 = 0; ld1 = 0; addr1 = 0; sdata1 = 0; sel1 = 0;
        st0 = 0; ld0 = 0; addr0 = 0; sdata0 = 0; sel0 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready1), 32'd1);
        chk("rst_data_l", ldata1, 32'h0);
        chk("rst_done", 32'({ld_done1, st_done1}), 32'd0);
`ifdef KMKZ_DM_ERR_EN
        chk("rst_err", 32'(err1), 32'd0);
`endif
        rst = 1'b1;

        // Store/load round trip with one wait state
        txn1(1'b1, 1'b0, 32'h10, 32'hA5A5_1234, 4'hF);
        txn1(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);

        // Byte-lane merge, and a store with no lanes enabled
        txn1(1'b1, 1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF);
        txn1(1'b1, 1'b0, 32'h20, 32'h0000_5500, 4'b0010);
        txn1(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        txn1(1'b1, 1'b0, 32'h20, 32'h1234_5678, 4'b0000);
        txn1(1'b0, 1'b1, 32'h22, 32'h0, 4'h0);

        // Load and store together resolve as a store
        txn1(1'b1, 1'b1, 32'h30, 32'h0000_0001, 4'hF);
        txn1(1'b0, 1'b1, 32'h30, 32'h0, 4'h0);

        // Reset in the middle of a store's wait cycle
        @(negedge clk);
        st1 = 1'b1; addr1 = 32'h10; sdata1 = 32'hDEAD_BEEF; sel1 = 4'hF;
        @(negedge clk);
        st1 = 1'b0;
        chk("abort_busy", 32'(ready1), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(ready1), 32'd1);
        chk("abort_data_l", ldata1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({ld_done1, st_done1}), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_done_post", 32'({ld_done1, st_done1}), 32'd0);
        chk("abort_ready_post", 32'(ready1), 32'd1);
        txn1(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);

        // Window edge: one word past the RAM
        txn1(1'b1, 1'b0, 32'h0, 32'h1357_9BDF, 4'hF);
        txn1(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0);
        txn1(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);

        // Zero wait states, requests held high
        burst0(1'b1);
        burst0(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
